// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU data-bus target: FSM states, bus widths, window decode.
package cpu_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESPOND
  } state_t;

  // 33-bit compare so a window ending at the top of the address space never wraps
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int               size_log2);
    logic [ADDR_W:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (offset < ((ADDR_W+1)'(4) << size_log2));
  endfunction

endpackage

// File: rtl/CPU_BRAM.sv
// Single-port block RAM, one-cycle synchronous read, write-first-free (read and write are exclusive).
// Latency 1 cycle for reads; no backpressure.
module CPU_BRAM #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1024,
  parameter int ADDR_LSH = 0,
  localparam int AW      = $clog2(SIZE)
) (
  input  logic                    i_clock,
  input  logic                    i_enable,
  input  logic                    i_write,
  input  logic [AW+ADDR_LSH-1:0]  i_address,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge i_clock) begin
    if (i_enable) begin
      if (i_write) begin
        mem[i_address[ADDR_LSH +: AW]] <= i_wdata;
      end else begin
        o_rdata <= mem[i_address[ADDR_LSH +: AW]];
      end
    end
  end

endmodule

// File: rtl/cpu_bus_bram_target.sv
// CPU data-bus target backed by block RAM: ready arrives 2 + WAIT_STATES cycles after the request.
// The initiator holds i_request until o_ready; dropping it before RESPOND abandons the access.
module cpu_bus_bram_target
  import cpu_bus_pkg::*;
#(
  parameter int                SIZE        = 14,
  parameter logic [ADDR_W-1:0] BASE        = 32'h0000_0000,
  parameter int                WAIT_STATES = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_request,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_error,
  output logic [31:0]       o_read_count,
  output logic [31:0]       o_write_count
);

  state_t              state;
  state_t              state_nxt;
  logic                start;
  logic                rw_q;
  logic                inwin_q;
  logic [SIZE-1:0]     index_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wait_q;
  logic [31:0]         read_cnt;
  logic [31:0]         write_cnt;
  logic                bram_en;
  logic                bram_we;
  logic [DATA_W-1:0]   bram_rdata;
  logic                rd_done;
  logic                wr_done;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (i_request) begin
          start     = 1'b1;
          state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!i_request) begin
          state_nxt = IDLE;
        end else if (wait_q == 4'd1) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = i_request ? RESPOND : IDLE;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      read_cnt  <= '0;
      write_cnt <= '0;
    end else begin
      state     <= state_nxt;
      read_cnt  <= read_cnt + 32'(rd_done);
      write_cnt <= write_cnt + 32'(wr_done);
    end
  end

  // Request fields are captured once; later input changes during the access are ignored
  always_ff @(posedge i_clock) begin
    if (start) begin
      rw_q    <= i_rw;
      inwin_q <= in_window(i_address, BASE, SIZE);
      index_q <= SIZE'((i_address - BASE) >> 2);
      wdata_q <= i_wdata;
      wait_q  <= 4'(WAIT_STATES);
    end else if (state == WAIT) begin
      wait_q  <= wait_q - 4'd1;
    end
  end

  assign bram_en = (state == ACCESS) && inwin_q && !i_reset;
  assign bram_we = bram_en && rw_q;

  CPU_BRAM #(
    .WIDTH    (DATA_W),
    .SIZE     (1 << SIZE),
    .ADDR_LSH (0)
  ) u_bram (
    .i_clock   (i_clock),
    .i_enable  (bram_en),
    .i_write   (bram_we),
    .i_address (index_q),
    .i_wdata   (wdata_q),
    .o_rdata   (bram_rdata)
  );

  assign rd_done       = (state == RESPOND) && inwin_q && !rw_q;
  assign wr_done       = (state == RESPOND) && inwin_q && rw_q;
  assign o_ready       = (state == RESPOND);
  assign o_error       = o_ready && !inwin_q;
  assign o_rdata       = rd_done ? bram_rdata : '0;
  assign o_read_count  = read_cnt;
  assign o_write_count = write_cnt;

endmodule

// File: tb/tb_cpu_bus_bram_target.sv
// Bench for cpu_bus_bram_target: three instances (0, 3 and 2 wait states) against a transaction-level model.
module tb_cpu_bus_bram_target;

  localparam int          SZ   = 8;
  localparam logic [31:0] BASE = 32'h0001_0000;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        rw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        err   [3];
  logic [31:0] rcnt  [3];
  logic [31:0] wcnt  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_bus_bram_target #(
      .SIZE        (SZ),
      .BASE        (BASE),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .i_clock       (clk),
      .i_reset       (rst[g]),
      .i_request     (req[g]),
      .i_rw          (rw[g]),
      .i_address     (addr[g]),
      .i_wdata       (wdata[g]),
      .o_rdata       (rdata[g]),
      .o_ready       (rdy[g]),
      .o_error       (err[g]),
      .o_read_count  (rcnt[g]),
      .o_write_count (wcnt[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          busy   [3];
  int          el     [3];
  bit          m_rw   [3];
  bit          m_in   [3];
  int unsigned m_idx  [3];
  logic [31:0] m_wd   [3];
  logic [31:0] m_rd   [3];
  bit          m_rdk  [3];
  logic [31:0] mc_r   [3];
  logic [31:0] mc_w   [3];
  logic [31:0] mem    [int];
  bit          e_rdy  [3];
  bit          e_err  [3];
  logic [31:0] e_rd   [3];
  bit          e_rdk  [3];
  int          cyc       = 0;
  int          wrap_tok  = 0;
  int          wrap_done = 0;

  function automatic void win_of(input logic [31:0] a, output bit inw, output int unsigned idx);
    longint off;
    off = longint'(a) - longint'(BASE);
    inw = (off >= 0) && (off < (longint'(4) << SZ));
    idx = inw ? int'(off >>> 2) : 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int ws;
      int key;
      ws = ws_of(k);
      if (rst[k]) begin
        busy[k] = 1'b0;
        mc_r[k] = '0;
        mc_w[k] = '0;
      end else if (!busy[k]) begin
        if (req[k]) begin
          busy[k] = 1'b1;
          el[k]   = 1;
          m_rw[k] = rw[k];
          m_wd[k] = wdata[k];
          win_of(addr[k], m_in[k], m_idx[k]);
        end
      end else if (el[k] == ws + 2) begin
        if (m_in[k] && m_rw[k])  mc_w[k] = mc_w[k] + 1;
        if (m_in[k] && !m_rw[k]) mc_r[k] = mc_r[k] + 1;
        busy[k] = 1'b0;
      end else begin
        if (el[k] == ws + 1 && m_in[k]) begin
          key = k * 4096 + int'(m_idx[k]);
          if (m_rw[k]) begin
            mem[key] = m_wd[k];
          end else begin
            m_rdk[k] = mem.exists(key);
            m_rd[k]  = m_rdk[k] ? mem[key] : 32'h0;
          end
        end
        if (!req[k]) busy[k] = 1'b0;
        else         el[k]   = el[k] + 1;
      end
      e_rdy[k] = busy[k] && (el[k] == ws + 2);
      e_err[k] = e_rdy[k] && !m_in[k];
      if (e_rdy[k] && m_in[k] && !m_rw[k]) begin
        e_rd[k]  = m_rd[k];
        e_rdk[k] = m_rdk[k];
      end else begin
        e_rd[k]  = '0;
        e_rdk[k] = 1'b1;
      end
    end
    if (wrap_tok != wrap_done) begin
      mc_r[0]   = 32'hFFFF_FFFF;
      wrap_done = wrap_tok;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("i%0d_ready", k), 32'(rdy[k]), 32'(e_rdy[k]));
        chk($sformatf("i%0d_error", k), 32'(err[k]), 32'(e_err[k]));
        chk($sformatf("i%0d_rcnt", k), rcnt[k], mc_r[k]);
        chk($sformatf("i%0d_wcnt", k), wcnt[k], mc_w[k]);
        if (e_rdk[k]) chk($sformatf("i%0d_rdata", k), rdata[k], e_rd[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int k, input bit cont, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit hold,
                     output logic [31:0] rd, output logic e, output int lat);
    if (!cont) @(negedge clk);
    req[k] = 1'b1; rw[k] = w; addr[k] = a; wdata[k] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy[k] && lat < 40);
    if (!rdy[k]) chk($sformatf("i%0d_timeout", k), 32'(rdy[k]), 32'd1);
    rd = rdata[k];
    e  = err[k];
    if (!hold) req[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_rcnt", rcnt[0], 32'd0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // write then read, no wait states
    txn(0, 0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 0, rd, e, lat);
    chk("wr_latency_ws0", lat, 32'd2);
    txn(0, 0, 0, BASE + 32'h10, 32'h0, 0, rd, e, lat);
    chk("rd_latency_ws0", lat, 32'd2);
    chk("rd_data_ws0", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("counts_wr", wcnt[0], 32'd1);
    chk("counts_rd", rcnt[0], 32'd1);

    // three wait states
    txn(1, 0, 1, BASE + 32'h10, 32'h0BAD_F00D, 0, rd, e, lat);
    txn(1, 0, 0, BASE + 32'h10, 32'h0, 0, rd, e, lat);
    chk("rd_latency_ws3", lat, 32'd5);
    chk("rd_data_ws3", rd, 32'h0BAD_F00D);

    // out-of-window accesses
    txn(0, 0, 0, BASE + (32'd4 << SZ), 32'h0, 0, rd, e, lat);
    chk("oow_error", 32'(e), 32'd1);
    chk("oow_rdata", rd, 32'd0);
    txn(0, 0, 1, BASE + 32'h3FC, 32'h5A5A_5A5A, 0, rd, e, lat);
    txn(0, 0, 1, BASE - 32'd4, 32'hBAD0_BAD0, 0, rd, e, lat);
    chk("oow_wr_error", 32'(e), 32'd1);
    txn(0, 0, 0, BASE + 32'h3FC, 32'h0, 0, rd, e, lat);
    chk("oow_mem_kept", rd, 32'h5A5A_5A5A);
    @(negedge clk);
    chk("oow_counts_wr", wcnt[0], 32'd2);
    chk("oow_counts_rd", rcnt[0], 32'd2);

    // back-to-back: write-back then fill with request held
    txn(0, 0, 1, BASE + 32'h40, 32'h2222_2222, 0, rd, e, lat);
    txn(0, 0, 1, BASE + 32'h20, 32'h1111_1111, 1, rd, e, lat);
    txn(0, 1, 0, BASE + 32'h40, 32'h0, 0, rd, e, lat);
    chk("b2b_read", rd, 32'h2222_2222);
    chk("b2b_latency", lat, 32'd3);
    txn(0, 0, 0, BASE + 32'h20, 32'h0, 0, rd, e, lat);
    chk("b2b_write_kept", rd, 32'h1111_1111);

    // aborted write with two wait states
    txn(2, 0, 1, BASE + 32'h80, 32'h3333_3333, 0, rd, e, lat);
    @(negedge clk);
    req[2] = 1'b1; rw[2] = 1'b1; addr[2] = BASE + 32'h80; wdata[2] = 32'h4444_4444;
    @(negedge clk);
    req[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(rdy[2]), 32'd0);
    end
    txn(2, 0, 0, BASE + 32'h80, 32'h0, 0, rd, e, lat);
    chk("abort_mem_kept", rd, 32'h3333_3333);

    // reset during WAIT
    @(negedge clk);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = BASE + 32'h10;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rst_wait_ready", 32'(rdy[1]), 32'd0);
    chk("rst_wait_rdata", rdata[1], 32'd0);
    chk("rst_wait_wcnt", wcnt[1], 32'd0);
    chk("rst_wait_rcnt", rcnt[1], 32'd0);
    chk("rst_wait_state", 32'(g_dut[1].u_dut.state), 32'(cpu_bus_pkg::IDLE));
    rst[1] = 1'b0;
    req[1] = 1'b0;

    // byte-address aliasing within a word
    txn(0, 0, 0, BASE + 32'h13, 32'h0, 0, rd, e, lat);
    chk("alias_read", rd, 32'hDEAD_BEEF);

    // read counter wrap
    @(negedge clk);
    #2;
    force g_dut[0].u_dut.read_cnt = 32'hFFFF_FFFF;
    wrap_tok++;
    @(negedge clk);
    #2;
    release g_dut[0].u_dut.read_cnt;
    txn(0, 0, 0, BASE + 32'h10, 32'h0, 0, rd, e, lat);
    @(negedge clk);
    chk("rcnt_wrap", rcnt[0], 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bram_target.md
Name: cpu_bus_bram_target

Overview:
- Bus responder (target) for the CPU data-bus request/ready protocol driven by the data cache and uncached pass-through paths.
- Decodes a byte-address window, services single-word reads and writes into a block RAM, and inserts programmable wait states.
- Reports out-of-window accesses and keeps read/write access counters.
- Sits between the cache bus port and on-chip memory; also usable as a bench memory model.

Parameters:
- SIZE, 14, log2 of word count (window = 4 << SIZE bytes).
- BASE, 32'h00000000, byte base address of the window; must be 4-byte aligned.
- WAIT_STATES, 0, extra cycles (0..15) inserted between access and ready.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  initiator holds high until ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address; bits [1:0] ignored.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data; valid only while o_ready = 1, otherwise 0.
- o_ready  out  1  single-cycle completion pulse.
- o_error  out  1  pulses with o_ready when the address is outside the window.
- o_read_count  out  32  completed in-window reads.
- o_write_count  out  32  completed in-window writes.

Behaviour:
- Interface (already decided): one clock, i_clock; reset i_reset is synchronous and active-high.
- Reset: o_ready = 0, o_rdata = 0, o_error = 0, both counters = 0, state = IDLE. BRAM write enable is forced 0 during any reset cycle. Memory contents are not cleared.
- Reset mid-transaction: abandon the transaction with no ready pulse. A write not yet in ACCESS is never committed.
- In-window test: i_address >= BASE and (i_address - BASE) < (4 << SIZE), using 33-bit compare with no wrap.
- Word index: (i_address - BASE)[SIZE+1:2].
- IDLE:
  - On i_request = 1, latch rw, address, wdata and the in-window flag.
  - Go to WAIT if WAIT_STATES > 0 (load counter = WAIT_STATES), else go to ACCESS.
- WAIT: decrement counter; go to ACCESS when counter reaches 1.
- ACCESS:
  - In window: drive the BRAM for exactly one cycle (write commits at the end of this cycle; read data is available the next cycle).
  - Out of window: no BRAM access.
  - Go to RESPOND.
- RESPOND:
  - o_ready = 1 for exactly this cycle.
  - o_rdata = BRAM data for an in-window read, else 0.
  - o_error = 1 if out of window.
  - Increment the matching counter for an in-window access; counters wrap at 2^32.
  - Go to IDLE.
- Latency: request first high in cycle N gives ready high in cycle N + 2 + WAIT_STATES, for reads and writes alike.
- Back-to-back: i_request still high in the cycle after RESPOND starts a new transaction.
  - Inputs are re-sampled in that cycle, so the initiator may change rw/address/wdata in the ready cycle (write-back followed by fill).
  - An initiator holding the same request repeats an idempotent access.
- Request dropped before RESPOND: return to IDLE next cycle with no ready pulse. A write already past ACCESS stays committed.
- Input changes while busy are ignored; only the latched values are used.

Decomposition:
- Package cpu_bus_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESPOND);
  - bus width constants (address 32, data 32);
  - the window-test helper function.
- Storage instantiates the existing CPU_BRAM sub-module (WIDTH 32, SIZE 1 << SIZE, ADDR_LSH 0).
- No other sub-modules.

Test Plan:
- Write then read, WAIT_STATES = 0:
  - Write 0xDEADBEEF to BASE+0x10 → ready in cycle N+2.
  - Read BASE+0x10 → o_rdata = 0xDEADBEEF in its ready cycle; o_write_count = 1, o_read_count = 1.
- WAIT_STATES = 3: read request at cycle 0 → ready only in cycle 5; o_ready and o_rdata are 0 in all other cycles.
- Out-of-window:
  - Read BASE + (4 << SIZE) → o_ready and o_error together, o_rdata = 0, counters unchanged.
  - Write to BASE−4 → memory unchanged (verify by a later read).
- Back-to-back with request held high:
  - Write 0x11111111 to A; in the ready cycle switch to a read of B (preloaded 0x22222222).
  - Read completes 2 cycles later with 0x22222222, and A holds 0x11111111.
- Abort and reset:
  - Drop request in cycle N+1 of a write (WAIT_STATES = 2) → no ready pulse and memory unchanged.
  - Assert i_reset during WAIT → next cycle outputs are 0, state is IDLE, and counters are cleared.
- Address aliasing: read BASE+0x13 returns the word at BASE+0x10; counter wrap forced from 0xFFFFFFFF → 0.
